// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : alu_mc
//  Purpose  : Multi-cycle ALU with valid/ready handshakes on both sides.
//             Single-cycle ops (logic, add/sub, compare, shifts) complete in
//             one clock and park in HOLD. The optional multiplier is a
//             shift-add unit that takes WIDTH clocks before HOLD.
//  Ports    : clk        - rising-edge clock
//             rst_n      - asynchronous active-low reset
//             in_valid   - operation offered
//             in_ready   - operation accepted when in_valid & in_ready
//             opcode     - [15:12] major, [7:4] ext, [7:0] imm
//             a, b       - WIDTH-bit operands
//             carry_in   - carry into ADD/ADDI
//             out_valid  - result/flags valid
//             out_ready  - consumer takes result when out_valid & out_ready
//             result     - WIDTH-bit result
//             flags      - {N,Z,F,L,C}
//  Config   : `define ALU_MC_MUL_EN to build the multiplier (RTYPE ext E).
//             Without it, ext E decodes as undefined.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    localparam logic [3:0] C_MAJ_RTYPE  = 4'h0;
    localparam logic [3:0] C_MAJ_ADDI   = 4'h5;
    localparam logic [3:0] C_MAJ_SHIFTS = 4'h8;
    localparam logic [3:0] C_MAJ_SUBI   = 4'h9;
    localparam logic [3:0] C_MAJ_CMPI   = 4'hB;

    localparam int C_FN = 4;
    localparam int C_FZ = 3;
    localparam int C_FF = 2;
    localparam int C_FL = 1;
    localparam int C_FC = 0;

    localparam logic [WIDTH-1:0] C_WIDTH_N = WIDTH'(WIDTH);

`ifdef ALU_MC_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd2
    } state_t;
`endif

    // ------------------------------------------------------------------
    // Shift helpers: amounts at or beyond WIDTH saturate explicitly.
    // ------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] f_shl(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] n);
        return (n >= C_WIDTH_N) ? '0 : (v << n);
    endfunction

    function automatic logic [WIDTH-1:0] f_shr(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] n);
        return (n >= C_WIDTH_N) ? '0 : (v >> n);
    endfunction

    function automatic logic [WIDTH-1:0] f_asr(input logic [WIDTH-1:0] v,
                                               input logic [WIDTH-1:0] n);
        return (n >= C_WIDTH_N) ? {WIDTH{v[WIDTH-1]}} : WIDTH'($signed(v) >>> n);
    endfunction

    // ------------------------------------------------------------------
    // Decode and single-cycle datapath
    // ------------------------------------------------------------------
    logic [3:0]       major;
    logic [3:0]       ext;
    logic [WIDTH-1:0] imm_sx;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] imm_amt;
    logic [WIDTH-1:0] reg_amt;
    logic [WIDTH-1:0] ashu_mag;
    logic [WIDTH-1:0] alu_res;
    logic [4:0]       alu_flags;
    logic             undef;
    logic             op_mul;
    logic             unused_opcode;

    assign major    = opcode[15:12];
    assign ext      = opcode[7:4];
    assign imm_sx   = WIDTH'($signed(opcode[7:0]));
    assign op_b     = (major == C_MAJ_RTYPE) ? b : imm_sx;
    assign sum      = {1'b0, a} + {1'b0, op_b} + {{WIDTH{1'b0}}, carry_in};
    // diff[WIDTH] is the borrow out of the subtraction.
    assign diff     = {1'b0, a} - {1'b0, op_b};
    assign imm_amt  = WIDTH'(opcode[3:0]);
    assign reg_amt  = WIDTH'(b[SHW-1:0]);
    // Magnitude of a negative b; the most negative value stays large and
    // therefore saturates to full sign fill.
    assign ashu_mag = b[WIDTH-1] ? (WIDTH'(0) - b) : b;
    // opcode[11:8] carries no meaning for any decoded instruction.
    assign unused_opcode = ^opcode[11:8];

    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        undef     = 1'b0;
        op_mul    = 1'b0;

        case (major)
            C_MAJ_RTYPE, C_MAJ_ADDI, C_MAJ_SUBI, C_MAJ_CMPI: begin
                // Immediate majors reuse the RTYPE arithmetic encodings.
                case ((major == C_MAJ_RTYPE) ? ext :
                      (major == C_MAJ_ADDI)  ? 4'h5 :
                      (major == C_MAJ_SUBI)  ? 4'h9 : 4'hB)
                    4'h1: alu_res = a & b;
                    4'h2: alu_res = a | b;
                    4'h3: alu_res = a ^ b;
                    4'h5: begin
                        alu_res         = sum[WIDTH-1:0];
                        alu_flags[C_FC] = sum[WIDTH];
                        alu_flags[C_FZ] = (sum[WIDTH-1:0] == '0);
                        alu_flags[C_FF] = (a[WIDTH-1] == op_b[WIDTH-1]) &&
                                          (sum[WIDTH-1] != a[WIDTH-1]);
                    end
                    4'h9: begin
                        alu_res         = diff[WIDTH-1:0];
                        alu_flags[C_FC] = diff[WIDTH];
                        alu_flags[C_FZ] = (diff[WIDTH-1:0] == '0);
                        alu_flags[C_FF] = (a[WIDTH-1] != op_b[WIDTH-1]) &&
                                          (diff[WIDTH-1] != a[WIDTH-1]);
                    end
                    4'hB: begin
                        alu_flags[C_FN] = ($signed(a) < $signed(op_b));
                        alu_flags[C_FL] = diff[WIDTH];
                        alu_flags[C_FZ] = (a == op_b);
                    end
`ifdef ALU_MC_MUL_EN
                    4'hE: op_mul = 1'b1;
`endif
                    default: undef = 1'b1;
                endcase
            end
            C_MAJ_SHIFTS: begin
                case (ext)
                    4'h0:    alu_res = f_shl(a, imm_amt);
                    4'h1:    alu_res = f_shr(a, imm_amt);
                    4'h2:    alu_res = f_shl(a, imm_amt);
                    4'h3:    alu_res = f_asr(a, imm_amt);
                    4'h4:    alu_res = f_shl(a, reg_amt);
                    4'h6:    alu_res = b[WIDTH-1] ? f_asr(a, ashu_mag) : f_shl(a, b);
                    default: undef = 1'b1;
                endcase
            end
            default: undef = 1'b1;
        endcase

        if (undef) begin
            alu_res   = '0;
            alu_flags = 5'b11111;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and output registers
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;
    logic             accept;

`ifdef ALU_MC_MUL_EN
    // prod holds {partial high half, remaining multiplier bits}; each step
    // adds the multiplicand into the high half and shifts right by one.
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]     mul_add;
    logic [2*WIDTH-1:0] mul_step;

    assign mul_add  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                      (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_add, prod_q[WIDTH-1:1]};
`endif

    assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
`ifdef ALU_MC_MUL_EN
        mcand_d     = mcand_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
`endif

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if ((state_q == ST_HOLD) && out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
                // A new op accepted while HOLD drains overrides the return
                // to IDLE, giving back-to-back results.
                if (accept) begin
`ifdef ALU_MC_MUL_EN
                    if (op_mul) begin
                        state_d     = ST_MUL;
                        out_valid_d = 1'b0;
                        mcand_d     = a;
                        prod_d      = {{WIDTH{1'b0}}, b};
                        cnt_d       = '0;
                    end else begin
                        state_d     = ST_HOLD;
                        result_d    = alu_res;
                        flags_d     = alu_flags;
                        out_valid_d = 1'b1;
                    end
`else
                    state_d     = ST_HOLD;
                    result_d    = alu_res;
                    flags_d     = alu_flags;
                    out_valid_d = 1'b1;
`endif
                end
            end
`ifdef ALU_MC_MUL_EN
            ST_MUL: begin
                prod_d = mul_step;
                cnt_d  = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d     = ST_HOLD;
                    result_d    = mul_step[WIDTH-1:0];
                    flags_d     = {1'b0, (mul_step[WIDTH-1:0] == '0), 1'b0, 1'b0,
                                   (mul_step[2*WIDTH-1:WIDTH] != '0)};
                    out_valid_d = 1'b1;
                end
            end
`endif
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
`ifdef ALU_MC_MUL_EN
            mcand_q     <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_MC_MUL_EN
            mcand_q     <= mcand_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign result    = result_q;
    assign flags     = flags_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_mc
//  Purpose  : Self-checking bench for alu_mc (WIDTH=16). Directed vectors
//             plus randomized ops compared against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

    localparam int     W = 16;
    localparam longint M = 64'd1 << W;
`ifdef ALU_MC_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [15:0]  opcode = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [4:0]   flags;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint sgn(input longint x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    function automatic bit ovf(input longint s);
        return (s >= M / 2) || (s < -(M / 2));
    endfunction

    // Reference: classify the instruction, then evaluate with integer maths.
    // Returns {result, flags{N,Z,F,L,C}}.
    function automatic logic [W+4:0] model(input logic [15:0] op, input logic [W-1:0] av,
                                           input logic [W-1:0] bv, input logic ci);
        longint ua, ub, x, r, s, n, d, q;
        logic [4:0] f;
        int kind;
        ua = av; ub = bv; r = 0; f = '0; n = 0; kind = -1;
        x = longint'(op[7:0]);
        if (x >= 128) x = x - 256;
        x = (x + M) % M;
        case (op[15:12])
            4'h0: begin
                x = ub;
                if (op[7:4] inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB}) kind = op[7:4];
                if (op[7:4] == 4'hE && MUL_ON) kind = 14;
            end
            4'h5: kind = 5;
            4'h9: kind = 9;
            4'hB: kind = 11;
            4'h8: begin
                n = op[3:0];
                case (op[7:4])
                    4'h0, 4'h2: kind = 20;
                    4'h1:       kind = 21;
                    4'h3:       kind = 22;
                    4'h4: begin kind = 20; n = ub % W; end
                    4'h6: begin
                        s = sgn(ub);
                        if (s >= 0) begin kind = 20; n = s; end
                        else begin kind = 22; n = -s; end
                    end
                    default: kind = -1;
                endcase
            end
            default: kind = -1;
        endcase
        case (kind)
            1: r = ua & x;
            2: r = ua | x;
            3: r = ua ^ x;
            5: begin
                s = ua + x + ci;
                r = s % M;
                f[0] = (s >= M);
                f[2] = ovf(sgn(ua) + sgn(x) + ci);
                f[3] = (r == 0);
            end
            9: begin
                r = (ua - x + M) % M;
                f[0] = (ua < x);
                f[2] = ovf(sgn(ua) - sgn(x));
                f[3] = (r == 0);
            end
            11: begin
                f[4] = (sgn(ua) < sgn(x));
                f[1] = (ua < x);
                f[3] = (ua == x);
            end
            14: begin
                s = ua * ub;
                r = s % M;
                f[0] = ((s / M) != 0);
                f[3] = (r == 0);
            end
            20: r = (n >= W) ? 0 : (ua * (64'd1 << n)) % M;
            21: r = (n >= W) ? 0 : ua / (64'd1 << n);
            22: begin
                s = sgn(ua);
                if (n >= W) r = (s < 0) ? M - 1 : 0;
                else begin
                    d = 64'd1 << n;
                    q = s / d;
                    if (s < 0 && q * d != s) q = q - 1;
                    r = (q + M) % M;
                end
            end
            default: f = 5'b11111;
        endcase
        return {r[W-1:0], f};
    endfunction

    // Offer one op, scramble inputs after acceptance, check latency, busy
    // cycles, result and flags, then optionally stall before consuming.
    task automatic run_op(input string tag, input logic [15:0] op, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic ci, input int stall,
                          output logic [W-1:0] r_o, output logic [4:0] f_o);
        logic [W+4:0] exp;
        int lat, busy, n;
        bit mul;
        exp = model(op, av, bv, ci);
        mul = MUL_ON && (op[15:12] == 4'h0) && (op[7:4] == 4'hE);
        @(negedge clk);
        in_valid = 1'b1; opcode = op; a = av; b = bv; carry_in = ci; out_ready = 1'b0;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        chk({tag, "/in_ready"}, 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        opcode = 16'($urandom); a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
        lat = 1; busy = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            if (!in_ready) busy++;
            @(negedge clk);
            lat++;
        end
        chk({tag, "/latency"}, lat, mul ? W + 1 : 1);
        chk({tag, "/busy"}, busy, mul ? W : 0);
        chk({tag, "/result"}, 32'(result), 32'(exp[W+4:5]));
        chk({tag, "/flags"}, 32'(flags), 32'(exp[4:0]));
        r_o = result; f_o = flags;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "/hold_valid"}, 32'(out_valid), 1);
            chk({tag, "/hold_result"}, 32'(result), 32'(exp[W+4:5]));
            chk({tag, "/hold_flags"}, 32'(flags), 32'(exp[4:0]));
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "/drained"}, 32'(out_valid), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] r;
        logic [4:0]   f;
        logic [15:0]  op;
        logic [15:0]  tbl [16];
        int           sel, cnt, tmp;
        tbl = '{16'h0010, 16'h0020, 16'h0030, 16'h0050, 16'h0090, 16'h00B0, 16'h00E0,
                16'h5000, 16'h9000, 16'hB000, 16'h8000, 16'h8010, 16'h8020, 16'h8030,
                16'h8040, 16'h8060};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_flags", 32'(flags), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);

        // Directed vectors
        run_op("add_ovf", 16'h0050, 16'h7FFF, 16'h0001, 1'b0, 1, r, f);
        chk("add_ovf_res", 32'(r), 32'h8000);
        chk("add_ovf_flg", 32'(f), 32'b00100);
        run_op("subi", 16'h9001, 16'h0000, 16'h1234, 1'b0, 0, r, f);
        chk("subi_res", 32'(r), 32'hFFFF);
        chk("subi_flg", 32'(f), 32'b00001);
        run_op("cmp", 16'h00B0, 16'hFFFF, 16'h0001, 1'b0, 0, r, f);
        chk("cmp_res", 32'(r), 0);
        chk("cmp_flg", 32'(f), 32'b10000);
        run_op("mul", 16'h00E0, 16'h0100, 16'h0100, 1'b0, 0, r, f);
        chk("mul_res", 32'(r), 0);
        chk("mul_flg", 32'(f), MUL_ON ? 32'b01001 : 32'b11111);
        run_op("ashu", 16'h8060, 16'h8000, 16'hFFFC, 1'b0, 0, r, f);
        chk("ashu_res", 32'(r), 32'hF800);
        chk("ashu_flg", 32'(f), 0);
        run_op("undef", 16'hF000, 16'h1234, 16'h5678, 1'b1, 0, r, f);
        chk("undef_res", 32'(r), 0);
        chk("undef_flg", 32'(f), 32'b11111);

        // Back-to-back: held AND result, then XOR accepted while draining
        @(negedge clk);
        in_valid = 1'b1; opcode = 16'h0010; a = 16'h00FF; b = 16'hFFF0; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("b2b_hold_valid", 32'(out_valid), 1);
            chk("b2b_hold_result", 32'(result), 32'h00F0);
            chk("b2b_hold_flags", 32'(flags), 0);
        end
        in_valid = 1'b1; opcode = 16'h0030; a = 16'h1234; b = 16'h00FF; out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("b2b_next_valid", 32'(out_valid), 1);
        chk("b2b_next_result", 32'(result), 32'h12CB);
        chk("b2b_next_flags", 32'(flags), 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("b2b_drained", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        in_valid = 1'b1; opcode = MUL_ON ? 16'h00E0 : 16'h0050;
        a = 16'h0003; b = 16'h0005; carry_in = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_result", 32'(result), 0);
        chk("mid_rst_flags", 32'(flags), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 1);
        cnt = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk("post_rst_stale", cnt, 0);

        // Randomized ops against the model
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 15);
            op  = tbl[sel];
            if (op[15:12] inside {4'h5, 4'h9, 4'hB}) op[7:0] = 8'($urandom);
            else begin
                op[11:8] = 4'($urandom);
                op[3:0]  = 4'($urandom);
            end
            if ($urandom_range(0, 9) == 0) op = 16'($urandom);
            a = W'($urandom);
            b = W'($urandom);
            if (op[15:12] == 4'h8 && $urandom_range(0, 1) == 1) begin
                tmp = $urandom_range(0, 40);
                b = W'(tmp - 20);
            end
            if ($urandom_range(0, 7) == 0) b = a;
            run_op("rand", op, a, b, 1'($urandom), $urandom_range(0, 2), r, f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
